// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky illegal/timeout traps.
// Latency: 3 (BR), 4 (R/I/SW/LUI/JAL/JALR) or 5 (LW) cycles per instruction with zero memory wait.
// Backpressure: FETCH and MEM hold while mem_ready is low, trapping after TIMEOUT_CYCLES idle cycles.
module multicycle_controller #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             Jal,
  output logic             Jalr,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Wide enough to hold TIMEOUT_CYCLES-1; a width of 1 covers the disabled and trivial cases.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a given state and latched opcode; anything not set stays 0.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.mem_req = 1'b1;
      S_EXEC: begin
        c.alu_src = (op == OP_LW) || (op == OP_SW) || (op == OP_I) ||
                    (op == OP_LUI) || (op == OP_JALR);
        case (op)
          OP_BR:       c.alu_op = 2'b01;
          OP_JAL:      c.alu_op = 2'b11;
          OP_R, OP_I:  c.alu_op = 2'b10;
          default:     c.alu_op = 2'b00;
        endcase
        c.branch = (op == OP_BR);
        c.jal    = (op == OP_JAL);
        c.jalr   = (op == OP_JALR);
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.mem_we  = (op == OP_SW);
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (op == OP_LW);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BR) || (op == OP_LUI) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  state_t           state_q;
  ctrl_t            ctrl_q;
  logic [6:0]       op_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             timeout_q;
  logic [31:0]      wait_next;
  logic             tmo_hit;

  // Assert immediately, release two edges later so the FSM never sees a partial deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  // This idle cycle would be the TIMEOUT_CYCLES-th without mem_ready; 0 disables the trap.
  assign wait_next = {{(32 - WAIT_W){1'b0}}, wait_q} + 32'd1;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (wait_next == 32'(TIMEOUT_CYCLES));

  // Sequencer: state, latched opcode, wait/retire counters, sticky traps and registered controls.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_for(S_FETCH, 7'd0);
      op_q      <= 7'd0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
            ctrl_q  <= ctrl_for(S_DECODE, op_q);
          end else if (tmo_hit) begin
            state_q   <= S_TRAP;
            ctrl_q    <= ctrl_for(S_TRAP, op_q);
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= Opcode;
          if (is_legal(Opcode)) begin
            state_q <= S_EXEC;
            ctrl_q  <= ctrl_for(S_EXEC, Opcode);
          end else begin
            state_q   <= S_TRAP;
            ctrl_q    <= ctrl_for(S_TRAP, Opcode);
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_LW, OP_SW: begin
              state_q <= S_MEM;
              ctrl_q  <= ctrl_for(S_MEM, op_q);
              wait_q  <= '0;
            end
            OP_BR: begin
              state_q   <= S_FETCH;
              ctrl_q    <= ctrl_for(S_FETCH, op_q);
              wait_q    <= '0;
              retired_q <= retired_q + CNT_W'(1);
            end
            default: begin
              state_q <= S_WB;
              ctrl_q  <= ctrl_for(S_WB, op_q);
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LW) begin
              state_q <= S_WB;
              ctrl_q  <= ctrl_for(S_WB, op_q);
            end else begin
              state_q   <= S_FETCH;
              ctrl_q    <= ctrl_for(S_FETCH, op_q);
              wait_q    <= '0;
              retired_q <= retired_q + CNT_W'(1);
            end
          end else if (tmo_hit) begin
            state_q   <= S_TRAP;
            ctrl_q    <= ctrl_for(S_TRAP, op_q);
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          ctrl_q    <= ctrl_for(S_FETCH, op_q);
          wait_q    <= '0;
          retired_q <= retired_q + CNT_W'(1);
        end
        S_TRAP: begin
          state_q <= S_TRAP;
          ctrl_q  <= ctrl_for(S_TRAP, op_q);
        end
        default: begin
          state_q <= S_TRAP;
          ctrl_q  <= ctrl_for(S_TRAP, op_q);
        end
      endcase
    end
  end

  assign mem_req  = ctrl_q.mem_req;
  assign mem_we   = ctrl_q.mem_we;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign Branch   = ctrl_q.branch;
  assign Jal      = ctrl_q.jal;
  assign Jalr     = ctrl_q.jalr;
  assign ALUOp    = ctrl_q.alu_op;
  // Instruction fetch completes in the same cycle memory answers.
  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign pc_write = (state_q == S_FETCH) && mem_ready;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model plus per-cycle compare.
// Latency: model predicts one expected observation per driven cycle.
// Backpressure: mem_ready patterns are directed per instruction (fetch/mem wait counts).
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int TO = 15;
  localparam int CW = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    Opcode;
  logic          mem_ready;
  logic          mem_req, mem_we, ir_write, pc_write;
  logic          ALUSrc, MemtoReg, RegWrite, Branch, Jal, Jalr;
  logic [1:0]    ALUOp;
  logic          illegal, timeout;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_controller #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
    .Jal(Jal), .Jalr(Jalr), .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          mem_req, mem_we, ir_write, pc_write;
    logic          alusrc, memtoreg, regwrite, branch, jal, jalr;
    logic [1:0]    aluop;
    logic          illegal, timeout;
    logic [CW-1:0] retired;
  } obs_t;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc_no = 0;
  obs_t          exp_o;
  logic          exp_vld = 1'b0;
  logic [CW-1:0] m_ret;
  logic          m_ill, m_tmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BR) || (op == OP_LUI) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // Expected observation for a state number while executing instruction op.
  function automatic obs_t exp_for(input logic [2:0] st, input logic [6:0] op, input logic mr);
    obs_t e;
    e = '0;
    e.st      = st;
    e.illegal = m_ill;
    e.timeout = m_tmo;
    e.retired = m_ret;
    if (st == 3'd0) begin
      e.mem_req  = 1'b1;
      e.ir_write = mr;
      e.pc_write = mr;
    end
    if (st == 3'd2) begin
      e.alusrc = (op == OP_LW) || (op == OP_SW) || (op == OP_I) || (op == OP_LUI) || (op == OP_JALR);
      e.aluop  = (op == OP_BR) ? 2'b01 : (op == OP_JAL) ? 2'b11 :
                 ((op == OP_R) || (op == OP_I)) ? 2'b10 : 2'b00;
      e.branch = (op == OP_BR);
      e.jal    = (op == OP_JAL);
      e.jalr   = (op == OP_JALR);
    end
    if (st == 3'd3) begin
      e.mem_req = 1'b1;
      e.mem_we  = (op == OP_SW);
    end
    if (st == 3'd4) begin
      e.regwrite = 1'b1;
      e.memtoreg = (op == OP_LW);
    end
    return e;
  endfunction

  task automatic cyc(input logic [2:0] st, input logic mr, input logic [6:0] opc, input logic [6:0] iop);
    @(negedge clk);
    mem_ready = mr;
    Opcode    = opc;
    exp_o     = exp_for(st, iop, mr);
    exp_vld   = 1'b1;
    cyc_no++;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) cyc(3'd7, (i % 2) == 0, OP_R, OP_R);
  endtask

  task automatic retire();
    m_ret = m_ret + 1'b1;
  endtask

  // One instruction: wf/wm idle cycles before mem_ready in FETCH/MEM; ncyc counts cycles used.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, output int ncyc);
    int   k;
    logic done;
    ncyc = 0;
    k = 0; done = 1'b0;
    while (!done) begin
      cyc(3'd0, k == wf, OP_BAD, op); ncyc++;
      if (k == wf) done = 1'b1;
      else if (k + 1 == TO) begin m_tmo = 1'b1; trap_hold(3); return; end
      k++;
    end
    cyc(3'd1, 1'b1, op, op); ncyc++;
    if (!legal(op)) begin m_ill = 1'b1; trap_hold(3); return; end
    cyc(3'd2, 1'b1, OP_BAD, op); ncyc++;
    if (op == OP_BR) begin retire(); return; end
    if ((op == OP_LW) || (op == OP_SW)) begin
      k = 0; done = 1'b0;
      while (!done) begin
        cyc(3'd3, k == wm, OP_BAD, op); ncyc++;
        if (k == wm) done = 1'b1;
        else if (k + 1 == TO) begin m_tmo = 1'b1; trap_hold(3); return; end
        k++;
      end
      if (op == OP_SW) begin retire(); return; end
    end
    cyc(3'd4, 1'b1, OP_BAD, op); ncyc++;
    retire();
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_ret = '0; m_ill = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    exp_vld   = 1'b0;
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    release_reset();
  endtask

  // Compare process: every driven cycle, DUT outputs against the model.
  initial begin
    obs_t act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_vld) begin
        act = '0;
        act.st = state; act.mem_req = mem_req; act.mem_we = mem_we;
        act.ir_write = ir_write; act.pc_write = pc_write; act.alusrc = ALUSrc;
        act.memtoreg = MemtoReg; act.regwrite = RegWrite; act.branch = Branch;
        act.jal = Jal; act.jalr = Jalr; act.aluop = ALUOp; act.illegal = illegal;
        act.timeout = timeout; act.retired = retired;
        chk($sformatf("cycle%0d", cyc_no), 32'(act), 32'(exp_o));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; mem_ready = 1'b0; Opcode = '0;
    m_ret = '0; m_ill = 1'b0; m_tmo = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state",    32'(state),    32'd0);
    chk("rst_mem_req",  32'(mem_req),  32'd1);
    chk("rst_retired",  32'(retired),  32'd0);
    chk("rst_illegal",  32'(illegal),  32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    release_reset();

    run_instr(OP_R, 0, 0, n);   chk("r_cycles", 32'(n), 32'd4);
    peek();                     chk("r_retired", 32'(retired), 32'd1);
    run_instr(OP_LW, 0, 0, n);  chk("lw_cycles", 32'(n), 32'd5);
    run_instr(OP_SW, 0, 0, n);  chk("sw_cycles", 32'(n), 32'd4);
    peek();                     chk("lwsw_retired", 32'(retired), 32'd3);
    run_instr(OP_BR, 0, 0, n);  chk("br_cycles", 32'(n), 32'd3);
    run_instr(OP_JAL, 0, 0, n); chk("jal_cycles", 32'(n), 32'd4);
    run_instr(OP_JALR, 0, 0, n);
    run_instr(OP_LUI, 0, 0, n);
    run_instr(OP_I, 0, 0, n);
    peek();                     chk("mix_retired", 32'(retired), 32'd8);
    run_instr(OP_LW, 3, 14, n); chk("lw_wait_cycles", 32'(n), 32'd22);
    run_instr(OP_SW, 0, 2, n);  chk("sw_wait_cycles", 32'(n), 32'd6);
    peek();                     chk("wait_retired", 32'(retired), 32'd10);

    // Fetch never answered: trap after 15 idle cycles.
    run_instr(OP_R, 15, 0, n);
    #3;
    chk("tmo_state",   32'(state),   32'd7);
    chk("tmo_flag",    32'(timeout), 32'd1);
    chk("tmo_mem_req", 32'(mem_req), 32'd0);
    chk("tmo_retired", 32'(retired), 32'd10);

    // mem_ready on the 15th cycle wins.
    do_reset();
    run_instr(OP_R, 14, 0, n);  chk("edge_cycles", 32'(n), 32'd18);
    peek();
    chk("edge_timeout", 32'(timeout), 32'd0);
    chk("edge_retired", 32'(retired), 32'd1);

    run_instr(OP_BAD, 0, 0, n);
    #3;
    chk("ill_state",   32'(state),   32'd7);
    chk("ill_flag",    32'(illegal), 32'd1);
    chk("ill_mem_req", 32'(mem_req), 32'd0);
    chk("ill_retired", 32'(retired), 32'd1);

    // Reset in the middle of a store's MEM phase.
    do_reset();
    run_instr(OP_R, 0, 0, n);
    cyc(3'd0, 1'b1, OP_BAD, OP_SW);
    cyc(3'd1, 1'b1, OP_SW,  OP_SW);
    cyc(3'd2, 1'b1, OP_BAD, OP_SW);
    cyc(3'd3, 1'b0, OP_BAD, OP_SW);
    cyc(3'd3, 1'b0, OP_BAD, OP_SW);
    #3;
    chk("mid_pre_mem_we",  32'(mem_we),  32'd1);
    chk("mid_pre_retired", 32'(retired), 32'd1);
    exp_vld = 1'b0;
    reset   = 1'b0;
    #1;
    chk("mid_state",   32'(state),   32'd0);
    chk("mid_retired", 32'(retired), 32'd0);
    chk("mid_mem_we",  32'(mem_we),  32'd0);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    release_reset();

    // 17 instructions on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) run_instr(OP_R, 0, 0, n);
    peek();
    chk("wrap_retired", 32'(retired), 32'd1);

    // Load whose memory phase never completes.
    run_instr(OP_LW, 0, 15, n);
    #3;
    chk("memtmo_state",   32'(state),   32'd7);
    chk("memtmo_flag",    32'(timeout), 32'd1);
    chk("memtmo_illegal", 32'(illegal), 32'd0);
    chk("memtmo_retired", 32'(retired), 32'd1);

    exp_vld = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, max memory-wait cycles before trap; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Opcode  input  7  instruction opcode, valid in DECODE.
REQ-006 SHALL have port mem_ready  input  1  memory completes current request this cycle.
REQ-007 SHALL have ports mem_req, mem_we, ir_write, pc_write  output  1 each  memory request, memory write, instruction-register load, PC+4 load.
REQ-008 SHALL have ports ALUSrc, MemtoReg, RegWrite, Branch, Jal, Jalr  output  1 each  datapath controls, RV32I meaning.
REQ-009 SHALL have port ALUOp  output  2  00 load/store/lui/jalr, 01 branch, 10 R/I-type, 11 jal.
REQ-010 SHALL have ports illegal, timeout  output  1 each  sticky trap causes.
REQ-011 SHALL have ports state  output  3  current state; retired  output  CNT_W  completed instructions.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; other encodings SHALL go to TRAP next cycle.
REQ-013 SHALL recognise R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, LUI 0110111, JAL 1101111, JALR 1100111; all others illegal.
REQ-014 FETCH: mem_req=1, mem_we=0; on mem_ready ir_write=1, pc_write=1 same cycle, next DECODE; else stay.
REQ-015 DECODE: one cycle; Opcode latched into internal register; legal -> EXEC; illegal -> TRAP with illegal=1.
REQ-016 EXEC/MEM/WB outputs SHALL derive from the latched opcode only; Opcode input ignored outside DECODE.
REQ-017 EXEC: one cycle; ALUSrc=1 for LW/SW/I/LUI/JALR; ALUOp per REQ-009; Branch=1 for BR, Jal=1 for JAL, Jalr=1 for JALR.
REQ-018 EXEC next state: LW/SW -> MEM; BR -> FETCH (retire); all others -> WB.
REQ-019 MEM: mem_req=1, mem_we=1 only for SW; on mem_ready LW -> WB, SW -> FETCH (retire); else stay.
REQ-020 WB: one cycle; RegWrite=1; MemtoReg=1 only for LW; -> FETCH (retire).
REQ-021 All controls not listed for a state SHALL be 0 in that state (Moore, except ir_write/pc_write gated by mem_ready).
REQ-022 Retire: retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB; wraps from 2^CNT_W-1 to 0.
REQ-023 Wait counter SHALL clear on entry to FETCH or MEM and count cycles with mem_ready=0; reaching TIMEOUT_CYCLES SHALL go to TRAP with timeout=1.
REQ-024 mem_ready on the cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal transition, no timeout.
REQ-025 TRAP: all controls 0, mem_req=0; stays until reset; illegal/timeout held.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 reset low SHALL immediately force state=FETCH, retired=0, illegal=0, timeout=0, wait counter=0, latched opcode=0.
REQ-028 Outputs during reset SHALL be FETCH values (mem_req=1, others 0 unless mem_ready); reset mid-instruction abandons it without retiring.
REQ-029 Release SHALL be synchronised to clk; first active edge after release evaluates FETCH.

Verification
REQ-030 mem_ready=1 constant, R-type 0110011 -> states 0,1,2,4,0 over 4 cycles; RegWrite=1 in WB; ALUOp=10 in EXEC; retired=1.
REQ-031 mem_ready=1, LW then SW -> LW 5 cycles with MemtoReg=1 in WB; SW 4 cycles with mem_we=1 in MEM; retired=2.
REQ-032 BR 1100011 -> Branch=1, ALUOp=01 in EXEC, back to FETCH after 3 cycles; JAL -> Jal=1, ALUOp=11, RegWrite in WB.
REQ-033 Opcode 1111111 in DECODE -> TRAP next cycle, illegal=1, mem_req=0, retired unchanged until reset.
REQ-034 mem_ready=0 in FETCH for 15 cycles -> TRAP, timeout=1; repeat with mem_ready=1 on 15th cycle -> DECODE, timeout=0.
REQ-035 Reset asserted in MEM mid-SW -> immediate state=0, retired=0, mem_we=0; CNT_W=4 run of 17 instructions -> retired=1.
